// File: rtl/raw2rgb_bilinear.sv
// raw2rgb_bilinear: streaming 3x3 bilinear Bayer demosaic with valid/sof framing and interior crop.
// Defining RAW2RGB_WB_EN adds Gain_R/Gain_B white-balance ports and one extra output stage.
module raw2rgb_bilinear #(
  parameter int DATA_W       = 8,
  parameter int IMAGE_WIDTH  = 1920,
  parameter int IMAGE_HEIGHT = 1080,
  parameter int BAYER_PAT    = 0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Din_valid,
  input  logic              Din_sof,
  input  logic [DATA_W-1:0] RAW_Data,
`ifdef RAW2RGB_WB_EN
  input  logic [7:0]        Gain_R,
  input  logic [7:0]        Gain_B,
`endif
  output logic              Dout_valid,
  output logic              Dout_sof,
  output logic              Dout_eol,
  output logic [DATA_W-1:0] RED,
  output logic [DATA_W-1:0] GREEN,
  output logic [DATA_W-1:0] BLUE
);

  localparam int XW = $clog2(IMAGE_WIDTH);
  localparam int YW = $clog2(IMAGE_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);
  localparam logic [1:0]    PHASE  = 2'(BAYER_PAT);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
  typedef enum logic [1:0] {SITE_R = 2'b00, SITE_GR = 2'b01, SITE_GB = 2'b10, SITE_B = 2'b11} site_t;

  function automatic logic [DATA_W-1:0] avg4(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d);
    logic [DATA_W+1:0] sum;
    sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d} + (DATA_W+2)'(2);
    return sum[DATA_W+1:2];
  endfunction

  function automatic logic [DATA_W-1:0] avg2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + (DATA_W+1)'(1);
    return sum[DATA_W:1];
  endfunction

  state_t              state_r, state_s;
  logic [XW-1:0]       x_r, x_s, cur_x_s;
  logic [YW-1:0]       y_r, y_s, cur_y_s;
  logic                accept_s, interior_s;

  logic [DATA_W-1:0]   lb0_r [IMAGE_WIDTH];
  logic [DATA_W-1:0]   lb1_r [IMAGE_WIDTH];
  logic [DATA_W-1:0]   win_r [3][3];
  logic                s1_valid_r, s1_sof_r, s1_eol_r;
  site_t               site_r;

  logic [DATA_W-1:0]   red_s, green_s, blue_s;
  logic                st2_valid_r, st2_sof_r, st2_eol_r;
  logic [DATA_W-1:0]   st2_red_r, st2_green_r, st2_blue_r;

  // Frame FSM: resolves the coordinate of the incoming pixel and the next counter values.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    cur_x_s  = x_r;
    cur_y_s  = y_r;
    x_s      = x_r;
    y_s      = y_r;
    case (state_r)
      IDLE: begin
        if (Din_valid && Din_sof) begin
          accept_s = 1'b1;
          cur_x_s  = '0;
          cur_y_s  = '0;
          state_s  = ACTIVE;
        end else begin
          state_s  = IDLE;
        end
      end
      ACTIVE: begin
        if (Din_valid) begin
          accept_s = 1'b1;
          if (Din_sof) begin
            cur_x_s = '0;
            cur_y_s = '0;
          end else begin
            cur_x_s = x_r;
            cur_y_s = y_r;
          end
        end else begin
          accept_s = 1'b0;
        end
      end
      default: state_s = IDLE;
    endcase
    if (accept_s) begin
      if (cur_x_s == X_LAST) begin
        x_s = '0;
        if (cur_y_s == Y_LAST) begin
          y_s     = '0;
          state_s = IDLE;
        end else begin
          y_s = cur_y_s + YW'(1);
        end
      end else begin
        x_s = cur_x_s + XW'(1);
        y_s = cur_y_s;
      end
    end else begin
      x_s = x_r;
      y_s = y_r;
    end
  end

  assign interior_s = (cur_x_s >= X_TWO) && (cur_y_s >= Y_TWO);

  // Line buffers hold the two previous lines; contents need no reset.
  always_ff @(posedge Clk) begin
    if (accept_s) begin
      lb1_r[cur_x_s] <= lb0_r[cur_x_s];
      lb0_r[cur_x_s] <= RAW_Data;
    end
  end

  // Counters, FSM state and the 3x3 window; column 2 is the newest, row 2 the current line.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_r    <= IDLE;
      x_r        <= '0;
      y_r        <= '0;
      s1_valid_r <= 1'b0;
      s1_sof_r   <= 1'b0;
      s1_eol_r   <= 1'b0;
      site_r     <= SITE_R;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_r[r][c] <= '0;
        end
      end
    end else begin
      state_r    <= state_s;
      x_r        <= x_s;
      y_r        <= y_s;
      s1_valid_r <= accept_s && interior_s;
      s1_sof_r   <= accept_s && interior_s && (cur_x_s == X_TWO) && (cur_y_s == Y_TWO);
      s1_eol_r   <= accept_s && interior_s && (cur_x_s == X_LAST);
      if (accept_s) begin
        for (int r = 0; r < 3; r++) begin
          win_r[r][0] <= win_r[r][1];
          win_r[r][1] <= win_r[r][2];
        end
        win_r[0][2] <= lb1_r[cur_x_s];
        win_r[1][2] <= lb0_r[cur_x_s];
        win_r[2][2] <= RAW_Data;
        // Centre sits one pixel up-left, so its parity is the inverse of the incoming pixel's.
        site_r <= site_t'({~cur_y_s[0] ^ PHASE[1], ~cur_x_s[0] ^ PHASE[0]});
      end
    end
  end

  // Bilinear interpolation of the window centre according to its Bayer site.
  always_comb begin
    red_s   = '0;
    green_s = '0;
    blue_s  = '0;
    case (site_r)
      SITE_R: begin
        red_s   = win_r[1][1];
        green_s = avg4(win_r[0][1], win_r[2][1], win_r[1][0], win_r[1][2]);
        blue_s  = avg4(win_r[0][0], win_r[0][2], win_r[2][0], win_r[2][2]);
      end
      SITE_GR: begin
        red_s   = avg2(win_r[1][0], win_r[1][2]);
        green_s = win_r[1][1];
        blue_s  = avg2(win_r[0][1], win_r[2][1]);
      end
      SITE_GB: begin
        red_s   = avg2(win_r[0][1], win_r[2][1]);
        green_s = win_r[1][1];
        blue_s  = avg2(win_r[1][0], win_r[1][2]);
      end
      SITE_B: begin
        red_s   = avg4(win_r[0][0], win_r[0][2], win_r[2][0], win_r[2][2]);
        green_s = avg4(win_r[0][1], win_r[2][1], win_r[1][0], win_r[1][2]);
        blue_s  = win_r[1][1];
      end
      default: begin
        red_s   = '0;
        green_s = '0;
        blue_s  = '0;
      end
    endcase
  end

  // Interpolated pixel register; colour holds between valid pixels.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      st2_valid_r <= 1'b0;
      st2_sof_r   <= 1'b0;
      st2_eol_r   <= 1'b0;
      st2_red_r   <= '0;
      st2_green_r <= '0;
      st2_blue_r  <= '0;
    end else begin
      st2_valid_r <= s1_valid_r;
      st2_sof_r   <= s1_sof_r;
      st2_eol_r   <= s1_eol_r;
      if (s1_valid_r) begin
        st2_red_r   <= red_s;
        st2_green_r <= green_s;
        st2_blue_r  <= blue_s;
      end
    end
  end

`ifdef RAW2RGB_WB_EN
  function automatic logic [DATA_W-1:0] wb_gain(input logic [DATA_W-1:0] v, input logic [7:0] g);
    logic [DATA_W+7:0] prod;
    prod = {8'b0, v} * {{DATA_W{1'b0}}, g};
    if (|prod[DATA_W+7:DATA_W+6]) begin
      return '1;
    end else begin
      return prod[DATA_W+5:6];
    end
  endfunction

  // White-balance stage: Q2.6 gains on red and blue, truncated and saturated.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Dout_valid <= 1'b0;
      Dout_sof   <= 1'b0;
      Dout_eol   <= 1'b0;
      RED        <= '0;
      GREEN      <= '0;
      BLUE       <= '0;
    end else begin
      Dout_valid <= st2_valid_r;
      Dout_sof   <= st2_sof_r;
      Dout_eol   <= st2_eol_r;
      if (st2_valid_r) begin
        RED   <= wb_gain(st2_red_r, Gain_R);
        GREEN <= st2_green_r;
        BLUE  <= wb_gain(st2_blue_r, Gain_B);
      end
    end
  end
`else
  assign Dout_valid = st2_valid_r;
  assign Dout_sof   = st2_sof_r;
  assign Dout_eol   = st2_eol_r;
  assign RED        = st2_red_r;
  assign GREEN      = st2_green_r;
  assign BLUE       = st2_blue_r;
`endif

endmodule
